// File: rtl/bomb_pkg.sv
// Shared arena geometry, cell codes and slot state for the bomb layer.
package bomb_pkg;

    localparam int GRID  = 10;
    localparam int NCELL = GRID * GRID;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_BOMB   = 2'b01;
    localparam logic [1:0] CELL_FLAME  = 2'b10;
    localparam logic [1:0] CELL_CENTER = 2'b11;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_ARMED = 2'd1,
        SLOT_BLAST = 2'd2
    } slot_state_e;

    // Flat cell index x*10+y; caller must keep x,y inside the arena.
    function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return ({3'b000, x} * 7'd10) + {3'b000, y};
    endfunction

endpackage

// File: rtl/bomb_manager_if.sv
// Request, arena and grid bundle between the bomb manager and its neighbours.
interface bomb_manager_if;
    import bomb_pkg::*;

    // Requests are valid-only strobes with no ready: a bombX_v pulse is either
    // taken or silently dropped on the same edge; armed_X shows the outcome.
    logic              tick;
    logic [NCELL-1:0]  onedim_Arena;
    logic              bombA_v;
    logic [3:0]        bombA_x;
    logic [3:0]        bombA_y;
    logic              bombB_v;
    logic [3:0]        bombB_x;
    logic [3:0]        bombB_y;
    logic [NCELL-1:0]  Bomb_bit0;
    logic [NCELL-1:0]  Bomb_bit1;
    logic              armed_A;
    logic              armed_B;
    slot_state_e       dbg_state_a_o;
    slot_state_e       dbg_state_b_o;

    modport master (
        output tick, onedim_Arena,
        output bombA_v, bombA_x, bombA_y,
        output bombB_v, bombB_x, bombB_y,
        input  Bomb_bit0, Bomb_bit1, armed_A, armed_B,
        input  dbg_state_a_o, dbg_state_b_o
    );

    modport slave (
        input  tick, onedim_Arena,
        input  bombA_v, bombA_x, bombA_y,
        input  bombB_v, bombB_x, bombB_y,
        output Bomb_bit0, Bomb_bit1, armed_A, armed_B,
        output dbg_state_a_o, dbg_state_b_o
    );

endinterface

// File: rtl/bomb_slot.sv
// One player's bomb: latches its cell on accept, then runs fuse, blast and clear.
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_TICKS  = 8,
    parameter int unsigned FLAME_TICKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_i,
    input  logic        accept_i,
    input  logic [3:0]  x_i,
    input  logic [3:0]  y_i,
    input  logic        chain_i,
    output slot_state_e state_o,
    output logic [3:0]  x_o,
    output logic [3:0]  y_o
);

    slot_state_e state_q;
    logic [3:0]  x_q;
    logic [3:0]  y_q;
    logic [3:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_IDLE;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                SLOT_IDLE: begin
                    if (accept_i) begin
                        state_q <= SLOT_ARMED;
                        x_q     <= x_i;
                        y_q     <= y_i;
                        cnt_q   <= 4'(FUSE_TICKS);
                    end
                end
                SLOT_ARMED: begin
                    // Being caught in the other flame wins over a fuse tick.
                    if (chain_i) begin
                        state_q <= SLOT_BLAST;
                        cnt_q   <= 4'(FLAME_TICKS);
                    end else if (tick_i) begin
                        if (cnt_q == 4'd1) begin
                            state_q <= SLOT_BLAST;
                            cnt_q   <= 4'(FLAME_TICKS);
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                SLOT_BLAST: begin
                    if (tick_i) begin
                        if (cnt_q == 4'd1) begin
                            state_q <= SLOT_IDLE;
                            cnt_q   <= 4'd0;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= SLOT_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/bomb_manager.sv
// Live bomb layer: arbitrates placement requests, builds wall-bounded flames and
// decodes both slots into the 2-bit-per-cell grid.
module bomb_manager
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_TICKS  = 8,
    parameter int unsigned FLAME_TICKS = 2,
    parameter int          RADIUS      = 2
) (
    input logic           clk,
    input logic           rst_n,
    bomb_manager_if.slave bus
);

    localparam logic [NCELL-1:0] ONE_HOT0 = {{(NCELL-1){1'b0}}, 1'b1};

    slot_state_e      st_a, st_b;
    logic [3:0]       xa, ya, xb, yb;
    logic [6:0]       idx_a, idx_b;
    logic [NCELL-1:0] flame_a, flame_b, centre_v, flame_v, bomb_v;
    logic [NCELL-1:0] grid_bit0, grid_bit1;
    logic             chain_a, chain_b;
    logic             in_a, in_b;
    logic [6:0]       req_idx_a, req_idx_b;
    logic             free_a, free_b;
    logic             acc_a, acc_b;

    // Arms walk outward from the centre and stop before the first wall or edge.
    function automatic logic [NCELL-1:0] flame_mask(input logic [3:0] cx,
                                                    input logic [3:0] cy,
                                                    input logic [NCELL-1:0] walls);
        logic [NCELL-1:0] m;
        logic             arm_live;
        int               nx;
        int               ny;
        m = '0;
        m[cell_idx(cx, cy)] = 1'b1;
        for (int dir = 0; dir < 4; dir++) begin
            arm_live = 1'b1;
            for (int d = 1; d <= RADIUS; d++) begin
                nx = int'(cx);
                ny = int'(cy);
                case (dir)
                    0:       nx = nx + d;
                    1:       nx = nx - d;
                    2:       ny = ny + d;
                    default: ny = ny - d;
                endcase
                if (nx < 0 || nx >= GRID || ny < 0 || ny >= GRID) begin
                    arm_live = 1'b0;
                end else if (walls[7'(nx * GRID + ny)]) begin
                    arm_live = 1'b0;
                end
                if (arm_live) begin
                    m[7'(nx * GRID + ny)] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    assign idx_a = cell_idx(xa, ya);
    assign idx_b = cell_idx(xb, yb);

    assign flame_a = (st_a == SLOT_BLAST) ? flame_mask(xa, ya, bus.onedim_Arena) : '0;
    assign flame_b = (st_b == SLOT_BLAST) ? flame_mask(xb, yb, bus.onedim_Arena) : '0;

    assign centre_v = ((st_a == SLOT_BLAST) ? (ONE_HOT0 << idx_a) : '0)
                    | ((st_b == SLOT_BLAST) ? (ONE_HOT0 << idx_b) : '0);
    assign bomb_v   = ((st_a == SLOT_ARMED) ? (ONE_HOT0 << idx_a) : '0)
                    | ((st_b == SLOT_ARMED) ? (ONE_HOT0 << idx_b) : '0);
    assign flame_v  = flame_a | flame_b;

    assign chain_a = (st_a == SLOT_ARMED) && flame_b[idx_a];
    assign chain_b = (st_b == SLOT_ARMED) && flame_a[idx_b];

    always_comb begin
        logic [1:0] code;
        grid_bit0 = '0;
        grid_bit1 = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (centre_v[i])     code = CELL_CENTER;
            else if (flame_v[i]) code = CELL_FLAME;
            else if (bomb_v[i])  code = CELL_BOMB;
            else                 code = CELL_EMPTY;
            grid_bit1[i] = code[1];
            grid_bit0[i] = code[0];
        end
    end

    // Out-of-arena requests index cell 0 only to keep the lookup in range.
    assign in_a      = (bus.bombA_x < 4'(GRID)) && (bus.bombA_y < 4'(GRID));
    assign in_b      = (bus.bombB_x < 4'(GRID)) && (bus.bombB_y < 4'(GRID));
    assign req_idx_a = in_a ? cell_idx(bus.bombA_x, bus.bombA_y) : 7'd0;
    assign req_idx_b = in_b ? cell_idx(bus.bombB_x, bus.bombB_y) : 7'd0;

    assign free_a = in_a && !bus.onedim_Arena[req_idx_a]
                  && !grid_bit1[req_idx_a] && !grid_bit0[req_idx_a];
    assign free_b = in_b && !bus.onedim_Arena[req_idx_b]
                  && !grid_bit1[req_idx_b] && !grid_bit0[req_idx_b];

    assign acc_a = bus.bombA_v && (st_a == SLOT_IDLE) && free_a;
    assign acc_b = bus.bombB_v && (st_b == SLOT_IDLE) && free_b
                 && !(acc_a && (bus.bombA_x == bus.bombB_x) && (bus.bombA_y == bus.bombB_y));

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS), .FLAME_TICKS(FLAME_TICKS)) u_slot_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (bus.tick),
        .accept_i (acc_a),
        .x_i      (bus.bombA_x),
        .y_i      (bus.bombA_y),
        .chain_i  (chain_a),
        .state_o  (st_a),
        .x_o      (xa),
        .y_o      (ya)
    );

    bomb_slot #(.FUSE_TICKS(FUSE_TICKS), .FLAME_TICKS(FLAME_TICKS)) u_slot_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (bus.tick),
        .accept_i (acc_b),
        .x_i      (bus.bombB_x),
        .y_i      (bus.bombB_y),
        .chain_i  (chain_b),
        .state_o  (st_b),
        .x_o      (xb),
        .y_o      (yb)
    );

    assign bus.Bomb_bit0     = grid_bit0;
    assign bus.Bomb_bit1     = grid_bit1;
    assign bus.armed_A       = (st_a != SLOT_IDLE);
    assign bus.armed_B       = (st_b != SLOT_IDLE);
    assign bus.dbg_state_a_o = st_a;
    assign bus.dbg_state_b_o = st_b;

endmodule

// File: tb/tb_bomb_manager.sv
// Directed bench for bomb_manager with FUSE_TICKS=8, FLAME_TICKS=2, RADIUS=2.
module tb_bomb_manager;
  import bomb_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  bomb_manager_if bus();

  bomb_manager #(.FUSE_TICKS(8), .FLAME_TICKS(2), .RADIUS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] code_at(input int i);
    return {bus.Bomb_bit1[i], bus.Bomb_bit0[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.tick    = 1'b0;
    bus.bombA_v = 1'b0;
    bus.bombA_x = 4'd0;
    bus.bombA_y = 4'd0;
    bus.bombB_v = 1'b0;
    bus.bombB_x = 4'd0;
    bus.bombB_y = 4'd0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    bus.onedim_Arena = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
    end
  endtask

  task automatic req(input bit is_b, input logic [3:0] x, input logic [3:0] y);
    if (is_b) begin
      bus.bombB_v = 1'b1; bus.bombB_x = x; bus.bombB_y = y;
    end else begin
      bus.bombA_v = 1'b1; bus.bombA_x = x; bus.bombA_y = y;
    end
    step();
    bus.bombA_v = 1'b0;
    bus.bombB_v = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.onedim_Arena = '0;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0) begin
      n_fail++;
      $display("FAIL reset_grid got %h/%h want 0", bus.Bomb_bit1, bus.Bomb_bit0);
    end
    n_cmp++;
    if ({bus.armed_A, bus.armed_B} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_armed got %b%b want 00", bus.armed_A, bus.armed_B);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_fuse();
    int flame_cells[6];
    flame_cells = '{12, 13, 21, 31, 1, 10};
    apply_reset();
    bus.tick = 1'b1;
    req(0, 4'd1, 4'd1);
    bus.tick = 1'b0;
    n_cmp++;
    if (code_at(11) !== 2'b01 || bus.armed_A !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_a got code=%b armed=%b want 01/1", code_at(11), bus.armed_A);
    end
    do_ticks(7);
    n_cmp++;
    if (code_at(11) !== 2'b01) begin
      n_fail++;
      $display("FAIL fuse_7ticks got %b want 01", code_at(11));
    end
    do_ticks(1);
    n_cmp++;
    if (code_at(11) !== 2'b11) begin
      n_fail++;
      $display("FAIL blast_centre got %b want 11", code_at(11));
    end
    foreach (flame_cells[k]) begin
      n_cmp++;
      if (code_at(flame_cells[k]) !== 2'b10) begin
        n_fail++;
        $display("FAIL flame_arm cell %0d got %b want 10", flame_cells[k], code_at(flame_cells[k]));
      end
    end
    n_cmp++;
    if (code_at(14) !== 2'b00 || code_at(41) !== 2'b00 || code_at(0) !== 2'b00) begin
      n_fail++;
      $display("FAIL flame_reach got c14=%b c41=%b c0=%b want 00", code_at(14), code_at(41), code_at(0));
    end
    do_ticks(1);
    n_cmp++;
    if (code_at(11) !== 2'b11 || bus.armed_A !== 1'b1) begin
      n_fail++;
      $display("FAIL blast_hold got %b armed=%b want 11/1", code_at(11), bus.armed_A);
    end
    do_ticks(1);
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0 || bus.armed_A !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle got %h/%h armed=%b want 0/0/0", bus.Bomb_bit1, bus.Bomb_bit0, bus.armed_A);
    end
    req(0, 4'd2, 4'd2);
    n_cmp++;
    if (code_at(22) !== 2'b01 || bus.armed_A !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back got %b armed=%b want 01/1", code_at(22), bus.armed_A);
    end
  endtask

  task automatic test_wall();
    apply_reset();
    bus.onedim_Arena[12] = 1'b1;
    req(0, 4'd1, 4'd1);
    do_ticks(8);
    n_cmp++;
    if (code_at(12) !== 2'b00 || code_at(13) !== 2'b00) begin
      n_fail++;
      $display("FAIL wall_stop got c12=%b c13=%b want 00/00", code_at(12), code_at(13));
    end
    n_cmp++;
    if (code_at(11) !== 2'b11 || code_at(10) !== 2'b10) begin
      n_fail++;
      $display("FAIL wall_other got c11=%b c10=%b want 11/10", code_at(11), code_at(10));
    end
  endtask

  task automatic test_chain();
    apply_reset();
    req(0, 4'd3, 4'd3);
    do_ticks(5);
    req(1, 4'd3, 4'd4);
    n_cmp++;
    if (code_at(34) !== 2'b01 || bus.armed_B !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_b_arm got %b armed=%b want 01/1", code_at(34), bus.armed_B);
    end
    do_ticks(3);
    n_cmp++;
    if (code_at(33) !== 2'b11 || code_at(34) !== 2'b10 || bus.dbg_state_b_o !== SLOT_ARMED) begin
      n_fail++;
      $display("FAIL chain_pre got c33=%b c34=%b stB=%0d want 11/10/1", code_at(33), code_at(34), bus.dbg_state_b_o);
    end
    step();
    n_cmp++;
    if (code_at(34) !== 2'b11 || bus.dbg_state_b_o !== SLOT_BLAST) begin
      n_fail++;
      $display("FAIL chain_b_blast got c34=%b stB=%0d want 11/2", code_at(34), bus.dbg_state_b_o);
    end
    n_cmp++;
    if (code_at(33) !== 2'b11 || code_at(36) !== 2'b10 || code_at(31) !== 2'b10
        || code_at(53) !== 2'b10 || code_at(54) !== 2'b10) begin
      n_fail++;
      $display("FAIL chain_union got c33=%b c36=%b c31=%b c53=%b c54=%b want 11/10/10/10/10",
               code_at(33), code_at(36), code_at(31), code_at(53), code_at(54));
    end
    do_ticks(2);
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0 || {bus.armed_A, bus.armed_B} !== 2'b00) begin
      n_fail++;
      $display("FAIL chain_clear got %h/%h armed=%b%b want 0", bus.Bomb_bit1, bus.Bomb_bit0, bus.armed_A, bus.armed_B);
    end
  endtask

  task automatic test_same_cell();
    apply_reset();
    bus.bombB_v = 1'b1; bus.bombB_x = 4'd5; bus.bombB_y = 4'd5;
    req(0, 4'd5, 4'd5);
    n_cmp++;
    if (code_at(55) !== 2'b01 || bus.armed_A !== 1'b1 || bus.armed_B !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cell got c55=%b A=%b B=%b want 01/1/0", code_at(55), bus.armed_A, bus.armed_B);
    end
    req(0, 4'd2, 4'd2);
    n_cmp++;
    if (code_at(22) !== 2'b00 || code_at(55) !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_drop got c22=%b c55=%b want 00/01", code_at(22), code_at(55));
    end
    req(1, 4'd5, 4'd5);
    n_cmp++;
    if (bus.armed_B !== 1'b0) begin
      n_fail++;
      $display("FAIL occupied_drop got armed_B=%b want 0", bus.armed_B);
    end
  endtask

  task automatic test_drops();
    apply_reset();
    bus.onedim_Arena[44] = 1'b1;
    req(0, 4'd10, 4'd0);
    req(0, 4'd0, 4'd10);
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0 || bus.armed_A !== 1'b0) begin
      n_fail++;
      $display("FAIL range_drop got %h/%h armed=%b want 0", bus.Bomb_bit1, bus.Bomb_bit0, bus.armed_A);
    end
    req(0, 4'd4, 4'd4);
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0 || bus.armed_A !== 1'b0) begin
      n_fail++;
      $display("FAIL wall_drop got %h/%h armed=%b want 0", bus.Bomb_bit1, bus.Bomb_bit0, bus.armed_A);
    end
    req(1, 4'd7, 4'd7);
    do_ticks(8);
    req(0, 4'd7, 4'd8);
    n_cmp++;
    if (bus.armed_A !== 1'b0 || code_at(78) !== 2'b10 || code_at(77) !== 2'b11) begin
      n_fail++;
      $display("FAIL flame_drop got A=%b c78=%b c77=%b want 0/10/11", bus.armed_A, code_at(78), code_at(77));
    end
  endtask

  task automatic test_reset_mid_blast();
    apply_reset();
    req(0, 4'd1, 4'd1);
    req(1, 4'd6, 4'd6);
    do_ticks(8);
    n_cmp++;
    if (code_at(11) !== 2'b11 || code_at(66) !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset got c11=%b c66=%b want 11/11", code_at(11), code_at(66));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0 || {bus.armed_A, bus.armed_B} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset got %h/%h armed=%b%b want 0", bus.Bomb_bit1, bus.Bomb_bit0, bus.armed_A, bus.armed_B);
    end
    step();
    rst_n = 1'b1;
    do_ticks(2);
    step();
    n_cmp++;
    if ((bus.Bomb_bit0 | bus.Bomb_bit1) !== '0 || {bus.armed_A, bus.armed_B} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_release got %h/%h armed=%b%b want 0", bus.Bomb_bit1, bus.Bomb_bit0, bus.armed_A, bus.armed_B);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic_fuse();
    test_wall();
    test_chain();
    test_same_cell();
    test_drops();
    test_reset_mid_blast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bomb_manager.md
# bomb_manager

Owns the live bomb layer of the 10x10 arena, serving the bomb-placement requests the character controller issues (`bombA_*`, `bombB_*`). Runs each player's single bomb through fuse, blast and clear; computes wall-bounded cross-shaped flames and chain detonations. Drives the 2-bit-per-cell `Bomb_bit1`/`Bomb_bit0` grids back to the controller and the display.

## Interface
- FUSE_TICKS, 8, `tick` strobes from arm to detonation (1..15)
- FLAME_TICKS, 2, `tick` strobes a blast stays visible (1..15)
- RADIUS, 2, flame reach in cells along each arm (1..9)

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  one-cycle game time-base strobe
- onedim_Arena  in  100  wall map, bit x*10+y, 1 = wall
- bombA_v  in  1  player A place request, one cycle
- bombA_x, bombA_y  in  4 each  player A request cell
- bombB_v  in  1  player B place request
- bombB_x, bombB_y  in  4 each  player B request cell
- Bomb_bit0, Bomb_bit1  out  100 each  cell code, bit x*10+y
- armed_A, armed_B  out  1 each  slot busy (ARMED or BLAST)

## Operation
- Cell code {bit1,bit0}: 00 empty, 01 armed bomb, 10 flame arm, 11 blast centre. Priority when several apply: 11 > 10 > 01.
- One slot per player. Each slot has state IDLE/ARMED/BLAST, a 4-bit x, a 4-bit y and a 4-bit counter.
- Request accepted only if all of the following hold: the slot is IDLE, x<10, y<10, the cell is not a wall, and the current grid code at the cell is 00. Otherwise it is silently dropped.
- Both players request the same cell in the same cycle: A accepted, B dropped.
- Accept: the slot latches x,y, loads the counter with FUSE_TICKS and enters ARMED.
- ARMED: each `tick` decrements the counter. A `tick` while counter==1 enters BLAST with counter=FLAME_TICKS.
- Chain: if the slot is ARMED and its cell is covered by the other slot's flame, it enters BLAST on the next edge with counter=FLAME_TICKS. This overrides any `tick` decrement in the same cycle.
- BLAST: each `tick` decrements the counter. A `tick` while counter==1 returns to IDLE.
- Flame: the centre cell plus up to RADIUS cells in each of the four directions. Each arm stops before the first wall cell or the grid edge; walls are never flamed. Flame is computed from live `onedim_Arena` every cycle.
- Both slots in BLAST: flame cells are the OR of both flames.
- The grid is a pure combinational decode of the slot registers. No other state feeds it.

## Timing
- Reset: all slots IDLE, counters 0. `Bomb_bit0`=`Bomb_bit1`=0 and `armed_A`=`armed_B`=0, immediately and asynchronously.
- Reset mid-fuse or mid-blast: all bombs vanish. No blast is emitted on release.
- Request with `*_v` high at edge N is accepted at edge N. The cell reads 01 and `armed_*`=1 after edge N.
- Arm-to-blast time is exactly FUSE_TICKS `tick` strobes after acceptance. A `tick` coincident with the accepting edge does not count.
- Chain latency: one clock after the triggering flame appears.
- The slot returns to IDLE on the edge of its final blast `tick`. A new request from the same player is accepted from the following cycle.
- `tick` and a request in the same cycle: the request is evaluated against the pre-edge grid.

## Structure
- Package `bomb_pkg` holds:
  - GRID=10
  - cell code constants CELL_EMPTY/CELL_BOMB/CELL_FLAME/CELL_CENTER
  - slot state enum
  - index function x*10+y
- Sub-module `bomb_slot`, one instance per player: state, position, counter, fuse/blast/chain transitions. It exposes its state and position.
- Top level holds request arbitration, the flame generator (per slot, wall-bounded walk) and the grid decode.

## Test plan
- Reset, then A requests (1,1) on an empty map. After 1 clk, cell 11 = 01 and `armed_A`=1. After 8 ticks, cell 11 = 11, cells 12,13,21,31,01,10 = 10, and cell 14 = 00.
- Wall at (1,2), A bomb at (1,1), RADIUS=2. Blast shows (1,2) and (1,3) as 00.
- A at (3,3) armed first. B arms at (3,4) 5 ticks later. A blasts at tick 8; B reads 11 one clk later, despite 5 of B's 8 fuse ticks remaining.
- Both request (5,5) in the same cycle: A accepted, `armed_B`=0. A second A request while ARMED is ignored.
- Requests at (10,0), (0,10), onto a wall, and onto a flame cell: all dropped, grid unchanged.
- `rst_n` low mid-blast: both grids read 0 with no clock edge required, and remain empty after release.
